pipe_reg_chain: RTL

Parametrised elastic pipeline-register chain for the processor datapath's inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a WIDTH-bit payload through DEPTH registered stages with per-stage valid bits and a valid/ready handshake at both ends. Bubbles collapse. A global stall comes from the hazard unit, and a per-stage flush mask comes from branch resolution. It also reports occupancy and a saturating count of flushed entries.

---
 rtl/pipe_reg_chain.sv | 102 ++++++++++
 1 files changed

// File: rtl/pipe_reg_chain.sv
// Elastic pipeline-register chain: DEPTH valid/ready stages with collapsing
// bubbles, global stall, per-stage flush and a saturating flush counter.
module pipe_reg_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         inValid,
  input  logic [WIDTH-1:0]             inData,
  output logic                         inReady,
  output logic                         outValid,
  output logic [WIDTH-1:0]             outData,
  input  logic                         outReady,
  input  logic                         stall,
  input  logic [DEPTH-1:0]             flushMask,
  output logic [DEPTH-1:0]             stageValid,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [CNTW-1:0]              flushCount
);

  localparam int OCCW = $clog2(DEPTH+1);
  localparam int SUMW = CNTW + OCCW;

  logic [DEPTH-1:0] validQ;
  logic [DEPTH-1:0] validD;
  logic [DEPTH-1:0] movedValid;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] dataQ [DEPTH];
  logic [WIDTH-1:0] dataD [DEPTH];
  logic [CNTW-1:0]  flushCountQ;
  logic [CNTW-1:0]  flushCountD;
  logic [OCCW-1:0]  killCount;
  logic [SUMW-1:0]  flushSum;

  // Ready ripples from the output back to stage 0; an empty stage absorbs backpressure.
  always_comb begin : readyChain
    logic r;
    rdy = '0;
    r   = outReady & ~stall;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r      = (~validQ[i] | r) & ~stall;
      rdy[i] = r;
    end
  end

  always_comb begin
    movedValid = validQ;
    for (int i = 0; i < DEPTH; i++) begin
      dataD[i] = dataQ[i];
    end
    if (rdy[0]) begin
      movedValid[0] = inValid;
      dataD[0]      = inData;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (rdy[i]) begin
        movedValid[i] = validQ[i-1];
        dataD[i]      = dataQ[i-1];
      end
    end
    // The flush mask acts on what each stage would hold after this edge.
    validD    = movedValid & ~flushMask;
    killCount = '0;
    for (int i = 0; i < DEPTH; i++) begin
      killCount = killCount + OCCW'(movedValid[i] & flushMask[i]);
    end
    flushSum    = SUMW'(flushCountQ) + SUMW'(killCount);
    flushCountD = (|flushSum[SUMW-1:CNTW]) ? '1 : flushSum[CNTW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      validQ      <= '0;
      flushCountQ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dataQ[i] <= '0;
      end
    end else begin
      validQ      <= validD;
      flushCountQ <= flushCountD;
      for (int i = 0; i < DEPTH; i++) begin
        dataQ[i] <= dataD[i];
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCCW'(validQ[i]);
    end
  end

  assign inReady    = rdy[0];
  assign outValid   = validQ[DEPTH-1] & ~stall;
  assign outData    = dataQ[DEPTH-1];
  assign stageValid = validQ;
  assign flushCount = flushCountQ;

endmodule
